// File: rtl/uart_cmd_host.sv
// uart_cmd_host
//   Host-side UART command initiator for the debug link. One request
//   (cmd, addr, data) is sent as three back-to-back 8N2 frames on uart_tx.
//   Then 0-2 response bytes are collected on uart_rx. Each response start bit
//   is bounded by a timeout. Exactly one result is reported per request.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   clk_per_bit   clocks per UART bit, latched on accept (values < 4 -> 4)
//   req_*         request: valid/ready, cmd/addr/data bytes, rsp_len (3 -> 2)
//   rsp_valid     one-cycle result pulse; rsp_data/rsp_status hold until next
//   rsp_data      response bytes big-endian ({00,b0} or {b0,b1})
//   rsp_status    00 ok, 01 timeout, 10 framing error
//   uart_tx       serial out to target, idle high
//   uart_rx       serial in from target, asynchronous, idle high
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE. A requester must hold req_valid and the
// request fields stable until that edge. req_valid while busy has no effect.
// rsp_valid has no back-pressure.
module uart_cmd_host #(
  parameter int CLK_BITS = 10,
  parameter int TIMEOUT  = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CLK_BITS-1:0] clk_per_bit,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [7:0]          req_cmd,
  input  logic [7:0]          req_addr,
  input  logic [7:0]          req_data,
  input  logic [1:0]          req_rsp_len,
  output logic                rsp_valid,
  output logic [15:0]         rsp_data,
  output logic [1:0]          rsp_status,
  output logic                uart_tx,
  input  logic                uart_rx
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_FRAME   = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_TX, S_RX_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {RX_HUNT, RX_START, RX_DATA, RX_STOP} rx_phase_t;

  state_t              state;
  rx_phase_t           rx_phase;

  logic [CLK_BITS-1:0] n_q;
  logic [1:0]          len_q;
  logic [7:0]          addr_q;
  logic [7:0]          data_q;

  logic [10:0]         tx_shift;   // bit 0 is the bit currently on the line
  logic [3:0]          tx_bit;
  logic [1:0]          tx_byte;
  logic [CLK_BITS-1:0] clk_cnt;

  logic                rx_s1;
  logic                rx_s2;
  logic                rx_prev;
  logic [CLK_BITS-1:0] rx_cnt;
  logic [2:0]          rx_bit;
  logic [7:0]          rx_shift;
  logic [1:0]          rx_nbytes;
  logic [15:0]         rx_acc;
  logic [TO_W-1:0]     to_cnt;

  logic [CLK_BITS-1:0] n_sel;
  logic [CLK_BITS-1:0] n_m1;
  logic [CLK_BITS-1:0] n_half;
  logic [TO_W-1:0]     to_next;
  logic [1:0]          nb_next;
  logic [15:0]         acc_next;
  logic                rx_fall;

  assign n_sel    = (clk_per_bit < CLK_BITS'(4)) ? CLK_BITS'(4) : clk_per_bit;
  assign n_m1     = n_q - CLK_BITS'(1);
  assign n_half   = n_q >> 1;
  // Saturates so TIMEOUT == 0 (wait forever) cannot wrap.
  assign to_next  = (&to_cnt) ? to_cnt : to_cnt + TO_W'(1);
  assign nb_next  = rx_nbytes + 2'd1;
  assign acc_next = {rx_acc[7:0], rx_shift};
  assign rx_fall  = rx_prev & ~rx_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rx_phase   <= RX_HUNT;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= 16'h0000;
      rsp_status <= ST_OK;
      uart_tx    <= 1'b1;
      n_q        <= '0;
      len_q      <= 2'd0;
      addr_q     <= 8'h00;
      data_q     <= 8'h00;
      tx_shift   <= '1;
      tx_bit     <= 4'd0;
      tx_byte    <= 2'd0;
      clk_cnt    <= '0;
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      rx_cnt     <= '0;
      rx_bit     <= 3'd0;
      rx_shift   <= 8'h00;
      rx_nbytes  <= 2'd0;
      rx_acc     <= 16'h0000;
      to_cnt     <= '0;
    end else begin
      rx_s1     <= uart_rx;
      rx_s2     <= rx_s1;
      rx_prev   <= rx_s2;
      rsp_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (req_valid) begin
            state     <= S_TX;
            req_ready <= 1'b0;
            n_q       <= n_sel;
            len_q     <= (req_rsp_len == 2'd3) ? 2'd2 : req_rsp_len;
            addr_q    <= req_addr;
            data_q    <= req_data;
            tx_shift  <= {2'b11, req_cmd, 1'b0};
            uart_tx   <= 1'b0;
            tx_bit    <= 4'd0;
            tx_byte   <= 2'd0;
            clk_cnt   <= '0;
            rx_nbytes <= 2'd0;
            rx_acc    <= 16'h0000;
          end
        end

        S_TX: begin
          if (clk_cnt == n_m1) begin
            clk_cnt <= '0;
            if (tx_bit == 4'd10) begin
              if (tx_byte == 2'd2) begin
                // Last stop bit finished; the line is already high.
                if (len_q == 2'd0) begin
                  state      <= S_DONE;
                  rsp_valid  <= 1'b1;
                  rsp_data   <= 16'h0000;
                  rsp_status <= ST_OK;
                end else begin
                  state    <= S_RX_WAIT;
                  rx_phase <= RX_HUNT;
                  to_cnt   <= '0;
                end
              end else begin
                tx_byte  <= tx_byte + 2'd1;
                tx_bit   <= 4'd0;
                tx_shift <= {2'b11, (tx_byte == 2'd0) ? addr_q : data_q, 1'b0};
                uart_tx  <= 1'b0;
              end
            end else begin
              tx_bit   <= tx_bit + 4'd1;
              uart_tx  <= tx_shift[1];
              tx_shift <= {1'b1, tx_shift[10:1]};
            end
          end else begin
            clk_cnt <= clk_cnt + CLK_BITS'(1);
          end
        end

        S_RX_WAIT: begin
          case (rx_phase)
            RX_HUNT: begin
              if ((TIMEOUT != 0) && (to_cnt >= TO_LAST)) begin
                state      <= S_DONE;
                rsp_valid  <= 1'b1;
                rsp_data   <= rx_acc;
                rsp_status <= ST_TIMEOUT;
              end else begin
                to_cnt <= to_next;
                if (rx_fall) begin
                  rx_phase <= RX_START;
                  rx_cnt   <= CLK_BITS'(1);
                end
              end
            end
            RX_START: begin
              // The timeout keeps running until the start bit is confirmed,
              // so a short glitch does not extend the wait.
              to_cnt <= to_next;
              if (rx_cnt == n_half) begin
                if (!rx_s2) begin
                  rx_phase <= RX_DATA;
                  rx_cnt   <= CLK_BITS'(1);
                  rx_bit   <= 3'd0;
                  to_cnt   <= '0;
                end else begin
                  rx_phase <= RX_HUNT;
                end
              end else begin
                rx_cnt <= rx_cnt + CLK_BITS'(1);
              end
            end
            RX_DATA: begin
              if (rx_cnt == n_q) begin
                rx_cnt   <= CLK_BITS'(1);
                rx_shift <= {rx_s2, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
                if (rx_bit == 3'd7) rx_phase <= RX_STOP;
              end else begin
                rx_cnt <= rx_cnt + CLK_BITS'(1);
              end
            end
            RX_STOP: begin
              // Only the first stop bit is checked, so 8N1 and 8N2 both pass.
              if (rx_cnt == n_q) begin
                rx_acc    <= acc_next;
                rx_nbytes <= nb_next;
                to_cnt    <= '0;
                rx_phase  <= RX_HUNT;
                if (!rx_s2) begin
                  state      <= S_DONE;
                  rsp_valid  <= 1'b1;
                  rsp_data   <= acc_next;
                  rsp_status <= ST_FRAME;
                end else if (nb_next == len_q) begin
                  state      <= S_DONE;
                  rsp_valid  <= 1'b1;
                  rsp_data   <= acc_next;
                  rsp_status <= ST_OK;
                end
              end else begin
                rx_cnt <= rx_cnt + CLK_BITS'(1);
              end
            end
            default: rx_phase <= RX_HUNT;
          endcase
        end

        S_DONE: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          rx_phase  <= RX_HUNT;
        end

        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          uart_tx   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_host.sv
module tb_uart_cmd_host;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  clk_per_bit = 10'd16;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_cmd = 8'h00;
  logic [7:0]  req_addr = 8'h00;
  logic [7:0]  req_data = 8'h00;
  logic [1:0]  req_rsp_len = 2'd0;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_status;
  logic        uart_tx;
  logic        uart_rx = 1'b1;

  int total = 0;
  int bad = 0;

  // Monitor state
  int          cyc = 0;
  int          acc_cyc = 0;
  int          rsp_cyc = 0;
  int          rsp_count = 0;
  logic [15:0] last_data = '0;
  logic [1:0]  last_status = '0;
  logic        rdy_at_rsp = 1'b0;
  logic        rdy_after_rsp = 1'b0;
  logic        prev_rsp = 1'b0;

  // Bench UART model state
  int          tb_n = 16;
  logic [7:0]  tx_q[$];
  logic [7:0]  exp_q[$];

  uart_cmd_host #(.CLK_BITS(10), .TIMEOUT(4096)) dut (
    .clk(clk), .rst(rst), .clk_per_bit(clk_per_bit),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_addr(req_addr), .req_data(req_data),
    .req_rsp_len(req_rsp_len),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before 2ms");
    $fatal(1, "watchdog");
  end

  // Cycle-stamped monitor, sampled on the falling edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (prev_rsp) rdy_after_rsp = req_ready;
    prev_rsp = rsp_valid;
    if (req_valid && req_ready && !rst) acc_cyc = cyc;
    if (rsp_valid) begin
      rsp_count   = rsp_count + 1;
      rsp_cyc     = cyc;
      last_data   = rsp_data;
      last_status = rsp_status;
      rdy_at_rsp  = req_ready;
    end
  end

  // UART receiver model on uart_tx
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0 && !rst) begin
        repeat (tb_n / 2) @(negedge clk);
        if (uart_tx === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (tb_n) @(negedge clk);
            b[i] = uart_tx;
          end
          repeat (tb_n) @(negedge clk);
          tx_q.push_back(b);
        end
      end
    end
  end

  function automatic logic [23:0] tx_word();
    if (tx_q.size() != 3) return 24'hxxxxxx;
    return {tx_q[0], tx_q[1], tx_q[2]};
  endfunction

  function automatic logic [23:0] exp_word();
    if (exp_q.size() != 3) return 24'hzzzzzz;
    return {exp_q[0], exp_q[1], exp_q[2]};
  endfunction

  // Driver tasks (called at posedge+#1)
  task automatic do_req(input logic [7:0] c, input logic [7:0] a,
                        input logic [7:0] d, input logic [1:0] l, output bit ok);
    tx_q.delete();
    exp_q.delete();
    exp_q.push_back(c);
    exp_q.push_back(a);
    exp_q.push_back(d);
    req_cmd = c; req_addr = a; req_data = d; req_rsp_len = l;
    req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_val);
    logic [10:0] f;
    f = {1'b1, stop_val, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      uart_rx = f[i];
      repeat (tb_n) begin @(posedge clk); #1; end
    end
    uart_rx = 1'b1;
  endtask

  task automatic wait_rsp(input int prev, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rsp_count > prev) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Scenario tasks
  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    total++; if (rsp_data !== 16'h0000) begin bad++; $display("FAIL reset_rsp_data: got %h want 0000", rsp_data); end
    total++; if (rsp_status !== 2'b00) begin bad++; $display("FAIL reset_status: got %b want 00", rsp_status); end
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL reset_uart_tx: got %b want 1", uart_tx); end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_len0();
    bit ok; int prev;
    prev = rsp_count;
    do_req(8'h01, 8'h00, 8'h00, 2'd0, ok);
    wait_rsp(prev, 700, ok);
    total++; if (!ok) begin bad++; $display("FAIL len0_rsp: got none want rsp_valid"); end
    total++; if (rsp_cyc - acc_cyc !== 529) begin bad++; $display("FAIL len0_latency: got %0d want 529", rsp_cyc - acc_cyc); end
    total++; if (last_status !== 2'b00) begin bad++; $display("FAIL len0_status: got %b want 00", last_status); end
    total++; if (tx_word() !== exp_word()) begin bad++; $display("FAIL len0_tx_bytes: got %h want %h", tx_word(), exp_word()); end
    idle(5);
  endtask

  task automatic test_rsp1();
    bit ok; int prev;
    prev = rsp_count;
    do_req(8'h03, 8'h10, 8'h5C, 2'd1, ok);
    idle(528 + 50);
    send_rx(8'hA5, 1'b1);
    wait_rsp(prev, 500, ok);
    total++; if (!ok) begin bad++; $display("FAIL rsp1_rsp: got none want rsp_valid"); end
    total++; if (last_data !== 16'h00A5) begin bad++; $display("FAIL rsp1_data: got %h want 00A5", last_data); end
    total++; if (last_status !== 2'b00) begin bad++; $display("FAIL rsp1_status: got %b want 00", last_status); end
    total++; if ((rsp_cyc - acc_cyc) < 728 || (rsp_cyc - acc_cyc) > 740) begin
      bad++; $display("FAIL rsp1_latency: got %0d want 728..740", rsp_cyc - acc_cyc); end
    total++; if (tx_word() !== exp_word()) begin bad++; $display("FAIL rsp1_tx_bytes: got %h want %h", tx_word(), exp_word()); end
    idle(5);
  endtask

  task automatic test_rsp2();
    bit ok; int prev;
    prev = rsp_count;
    do_req(8'h05, 8'h20, 8'h00, 2'd2, ok);
    idle(528 + 20);
    send_rx(8'h12, 1'b1);
    send_rx(8'h34, 1'b1);
    wait_rsp(prev, 500, ok);
    idle(2);
    total++; if (!ok) begin bad++; $display("FAIL rsp2_rsp: got none want rsp_valid"); end
    total++; if (last_data !== 16'h1234) begin bad++; $display("FAIL rsp2_data: got %h want 1234", last_data); end
    total++; if (last_status !== 2'b00) begin bad++; $display("FAIL rsp2_status: got %b want 00", last_status); end
    total++; if (rdy_at_rsp !== 1'b0) begin bad++; $display("FAIL rsp2_ready_in_done: got %b want 0", rdy_at_rsp); end
    total++; if (rdy_after_rsp !== 1'b1) begin bad++; $display("FAIL rsp2_ready_after: got %b want 1", rdy_after_rsp); end
  endtask

  task automatic test_len3();
    bit ok; int prev;
    prev = rsp_count;
    do_req(8'h07, 8'h44, 8'h99, 2'd3, ok);
    idle(528 + 10);
    send_rx(8'h9C, 1'b1);
    send_rx(8'h3E, 1'b1);
    wait_rsp(prev, 500, ok);
    total++; if (!ok) begin bad++; $display("FAIL len3_rsp: got none want rsp_valid"); end
    total++; if (last_data !== 16'h9C3E) begin bad++; $display("FAIL len3_data: got %h want 9C3E", last_data); end
    total++; if (last_status !== 2'b00) begin bad++; $display("FAIL len3_status: got %b want 00", last_status); end
    idle(5);
  endtask

  task automatic test_timeout();
    bit ok; int prev;
    prev = rsp_count;
    do_req(8'h03, 8'h11, 8'h22, 2'd1, ok);
    idle(528 + 1000);
    uart_rx = 1'b0;
    idle(3);
    uart_rx = 1'b1;
    wait_rsp(prev, 5000, ok);
    total++; if (!ok) begin bad++; $display("FAIL timeout_rsp: got none want rsp_valid"); end
    total++; if (last_status !== 2'b01) begin bad++; $display("FAIL timeout_status: got %b want 01", last_status); end
    total++; if (last_data !== 16'h0000) begin bad++; $display("FAIL timeout_data: got %h want 0000", last_data); end
    total++; if ((rsp_cyc - acc_cyc) < 4625 || (rsp_cyc - acc_cyc) > 4629) begin
      bad++; $display("FAIL timeout_latency: got %0d want 4625..4629", rsp_cyc - acc_cyc); end
    idle(5);
  endtask

  task automatic test_framing();
    bit ok; int prev;
    prev = rsp_count;
    do_req(8'h03, 8'h12, 8'h00, 2'd1, ok);
    idle(528 + 30);
    send_rx(8'h5A, 1'b0);
    wait_rsp(prev, 500, ok);
    total++; if (!ok) begin bad++; $display("FAIL framing_rsp: got none want rsp_valid"); end
    total++; if (last_status !== 2'b10) begin bad++; $display("FAIL framing_status: got %b want 10", last_status); end
    total++; if (last_data !== 16'h005A) begin bad++; $display("FAIL framing_data: got %h want 005A", last_data); end
    idle(5);
  endtask

  task automatic test_min_bit();
    bit ok; int prev;
    clk_per_bit = 10'd2;
    tb_n = 4;
    prev = rsp_count;
    do_req(8'hC3, 8'h81, 8'h7E, 2'd0, ok);
    wait_rsp(prev, 300, ok);
    idle(5);
    total++; if (!ok) begin bad++; $display("FAIL minbit_rsp: got none want rsp_valid"); end
    total++; if (rsp_cyc - acc_cyc !== 133) begin bad++; $display("FAIL minbit_latency: got %0d want 133", rsp_cyc - acc_cyc); end
    total++; if (tx_word() !== exp_word()) begin bad++; $display("FAIL minbit_tx_bytes: got %h want %h", tx_word(), exp_word()); end
    clk_per_bit = 10'd16;
    tb_n = 16;
  endtask

  task automatic test_reset_mid();
    bit ok; int prev;
    prev = rsp_count;
    do_req(8'hEE, 8'h77, 8'h11, 2'd0, ok);
    idle(11 * 16 + 8);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL abort_uart_tx: got %b want 1", uart_tx); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", req_ready); end
    @(posedge clk); #1;
    idle(600);
    total++; if (rsp_count !== prev) begin bad++; $display("FAIL abort_no_rsp: got %0d want %0d", rsp_count, prev); end
    prev = rsp_count;
    do_req(8'hA6, 8'h3C, 8'hF0, 2'd0, ok);
    wait_rsp(prev, 700, ok);
    total++; if (!ok) begin bad++; $display("FAIL after_abort_rsp: got none want rsp_valid"); end
    total++; if (rsp_cyc - acc_cyc !== 529) begin bad++; $display("FAIL after_abort_latency: got %0d want 529", rsp_cyc - acc_cyc); end
    total++; if (last_status !== 2'b00) begin bad++; $display("FAIL after_abort_status: got %b want 00", last_status); end
    total++; if (tx_word() !== exp_word()) begin bad++; $display("FAIL after_abort_tx_bytes: got %h want %h", tx_word(), exp_word()); end
    idle(5);
  endtask

  initial begin
    test_reset();
    test_len0();
    test_rsp1();
    test_rsp2();
    test_len3();
    test_timeout();
    test_framing();
    test_min_bit();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
